// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/replay control for the 5-stage pipeline.
// Combines bus wait states, EX redirects and load-use dependencies into
// IF/ID select, PC enable and ID/EX bubble controls, plus a bus-stall
// watchdog and three performance counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        im_wait,
  input  logic        dm_wait,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_redirect,
  output logic [1:0]  bus_stall,
  output logic [1:0]  instr_sel,
  output logic        load_use,
  output logic        pc_en,
  output logic        id_ex_bubble,
  output logic        bus_timeout,
  output logic [31:0] cnt_lu,
  output logic [31:0] cnt_flush,
  output logic [31:0] cnt_bus
);

  typedef enum logic {RUN, REPLAY} state_t;

  localparam logic [1:0]  SEL_PASS   = 2'b00;
  localparam logic [1:0]  SEL_REPLAY = 2'b01;
  localparam logic [1:0]  SEL_NOP    = 2'b10;
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic        bs, hz;
  logic [15:0] stall_cnt;

  assign bs        = im_wait | dm_wait;
  assign bus_stall = {dm_wait, im_wait};
  assign hz        = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

  // State register; reset drops any pending replay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  // Next state and control outputs. Priority: bus stall > redirect > load-use.
  always_comb begin
    state_nx     = state;
    instr_sel    = SEL_PASS;
    load_use     = 1'b0;
    id_ex_bubble = 1'b0;
    pc_en        = 1'b0;
    if (rst) begin
      pc_en    = !bs;
      state_nx = RUN;
    end else begin
      case (state)
        RUN: begin
          if (bs) begin
            // whole pipeline frozen
          end else if (ex_redirect) begin
            instr_sel    = SEL_NOP;
            id_ex_bubble = 1'b1;
            pc_en        = 1'b1;
          end else if (hz) begin
            load_use     = 1'b1;
            id_ex_bubble = 1'b1;
            state_nx     = REPLAY;
          end else begin
            pc_en = 1'b1;
          end
        end
        REPLAY: begin
          // the held instruction is re-issued; hz is the same load, ignore it
          instr_sel = SEL_REPLAY;
          if (bs) begin
            // keep replaying until the bus frees up
          end else if (ex_redirect) begin
            instr_sel    = SEL_NOP;
            id_ex_bubble = 1'b1;
            pc_en        = 1'b1;
            state_nx     = RUN;
          end else begin
            pc_en    = 1'b1;
            state_nx = RUN;
          end
        end
      endcase
    end
  end

  // Watchdog: count consecutive bus-stall cycles, saturating so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      stall_cnt <= 16'd0;
    else if (!bs)                 stall_cnt <= 16'd0;
    else if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             bus_timeout <= 1'b0;
    else if (bs && (stall_cnt == TO_LAST)) bus_timeout <= 1'b1;
  end

  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_lu    <= 32'd0;
      cnt_flush <= 32'd0;
      cnt_bus   <= 32'd0;
    end else begin
      if (load_use)             cnt_lu    <= cnt_lu + 32'd1;
      if (instr_sel == SEL_NOP) cnt_flush <= cnt_flush + 32'd1;
      if (bs)                   cnt_bus   <= cnt_bus + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: each step drives inputs just after the rising edge
// and queues the expected outputs; a monitor pops and compares mid-cycle.
module tb_hazard_ctrl;

  logic        clk, rst, im_wait, dm_wait, ex_mem_read, id_use_rs1, id_use_rs2, ex_redirect;
  logic [4:0]  ex_rd, id_rs1, id_rs2;
  logic [1:0]  bus_stall, instr_sel;
  logic        load_use, pc_en, id_ex_bubble, bus_timeout;
  logic [31:0] cnt_lu, cnt_flush, cnt_bus;

  hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .im_wait(im_wait), .dm_wait(dm_wait),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_redirect(ex_redirect),
    .bus_stall(bus_stall), .instr_sel(instr_sel), .load_use(load_use), .pc_en(pc_en),
    .id_ex_bubble(id_ex_bubble), .bus_timeout(bus_timeout),
    .cnt_lu(cnt_lu), .cnt_flush(cnt_flush), .cnt_bus(cnt_bus)
  );

  typedef struct packed {
    logic [1:0]  bus;
    logic [1:0]  sel;
    logic        lu, pc, bub, to;
    logic [31:0] c_lu, c_fl, c_bus;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0, n_fail = 0;
  logic [31:0] e_lu = 0, e_fl = 0, e_bus = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: compare outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("bus_stall",    32'(bus_stall),    32'(e.bus));
      check("instr_sel",    32'(instr_sel),    32'(e.sel));
      check("load_use",     32'(load_use),     32'(e.lu));
      check("pc_en",        32'(pc_en),        32'(e.pc));
      check("id_ex_bubble", 32'(id_ex_bubble), 32'(e.bub));
      check("bus_timeout",  32'(bus_timeout),  32'(e.to));
      check("cnt_lu",       cnt_lu,            e.c_lu);
      check("cnt_flush",    cnt_flush,         e.c_fl);
      check("cnt_bus",      cnt_bus,           e.c_bus);
    end
  end

  // One cycle: inputs, then expected sel/load_use/pc_en/bubble/timeout.
  task automatic st(input logic r, iw, dw, mr, input logic [4:0] rd, rs1, input logic u1,
                    input logic [4:0] rs2, input logic u2, redir,
                    input logic [1:0] sel, input logic lu, pc, bub, to);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r; im_wait = iw; dm_wait = dw; ex_mem_read = mr; ex_rd = rd;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2; ex_redirect = redir;
    if (r) begin e_lu = 0; e_fl = 0; e_bus = 0; end
    e = '{bus: {dw, iw}, sel: sel, lu: lu, pc: pc, bub: bub, to: to,
          c_lu: e_lu, c_fl: e_fl, c_bus: e_bus};
    sb.push_back(e);
    if (!r) begin
      if (lu) e_lu++;
      if (sel == 2'b10) e_fl++;
      if (iw | dw) e_bus++;
    end
  endtask

  // lw x5 in EX, add x6,x5,x1 in ID
  task automatic hz_cyc(input logic to);
    st(0,0,0,1,5'd5,5'd5,1,5'd1,1,0, 2'b00,1,0,1,to);
  endtask
  task automatic idle(input logic [1:0] sel, input logic to);
    st(0,0,0,0,5'd0,5'd0,0,5'd0,0,0, sel,0,1,0,to);
  endtask

  initial begin
    rst = 1'b1; im_wait = 0; dm_wait = 0; ex_mem_read = 0; ex_rd = 0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_redirect = 0;

    // reset state
    st(1,0,0,0,5'd0,5'd0,0,5'd0,0,0, 2'b00,0,1,0,0);
    st(1,0,1,0,5'd0,5'd0,0,5'd0,0,0, 2'b00,0,0,0,0);   // pc_en follows !bs in reset
    idle(2'b00,0);

    // basic load-use: one bubble then replay
    hz_cyc(0);
    idle(2'b01,0);
    idle(2'b00,0);

    // load-use then 3 dm_wait cycles while replaying (also: 3 stalls < TIMEOUT)
    hz_cyc(0);
    st(0,0,1,0,5'd0,5'd0,0,5'd0,0,0, 2'b01,0,0,0,0);
    st(0,0,1,0,5'd0,5'd0,0,5'd0,0,0, 2'b01,0,0,0,0);
    st(0,0,1,1,5'd5,5'd5,1,5'd0,0,0, 2'b01,0,0,0,0);   // hz ignored in REPLAY
    st(0,0,0,1,5'd5,5'd5,1,5'd0,0,0, 2'b01,0,1,0,0);
    idle(2'b00,0);

    // redirect with hz: redirect wins, stays RUN
    st(0,0,0,1,5'd5,5'd5,1,5'd1,1,1, 2'b10,0,1,1,0);
    idle(2'b00,0);

    // ex_rd = 0 never stalls; unused matching source never stalls
    st(0,0,0,1,5'd0,5'd0,1,5'd0,1,0, 2'b00,0,1,0,0);
    st(0,0,0,1,5'd7,5'd7,0,5'd7,0,0, 2'b00,0,1,0,0);
    // hazard via rs2
    st(0,0,0,1,5'd9,5'd3,1,5'd9,1,0, 2'b00,1,0,1,0);
    idle(2'b01,0);

    // im_wait + redirect for 2 cycles, then redirect alone
    st(0,1,0,0,5'd0,5'd0,0,5'd0,0,1, 2'b00,0,0,0,0);
    st(0,1,0,0,5'd0,5'd0,0,5'd0,0,1, 2'b00,0,0,0,0);
    st(0,0,0,0,5'd0,5'd0,0,5'd0,0,1, 2'b10,0,1,1,0);
    idle(2'b00,0);

    // redirect during REPLAY returns to RUN
    hz_cyc(0);
    st(0,0,0,0,5'd0,5'd0,0,5'd0,0,1, 2'b10,0,1,1,0);
    idle(2'b00,0);

    // watchdog: 4 stall cycles with TIMEOUT = 4
    repeat (4) st(0,0,1,0,5'd0,5'd0,0,5'd0,0,0, 2'b00,0,0,0,0);
    idle(2'b00,1);
    idle(2'b00,1);

    // reset while in REPLAY: counters clear, no replay afterwards
    hz_cyc(1);
    st(1,0,0,0,5'd0,5'd0,0,5'd0,0,0, 2'b00,0,1,0,0);
    idle(2'b00,0);
    idle(2'b00,0);

    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It generates the per-cycle stall, flush and replay controls for the IF/ID register, the PC and the ID/EX register. Inputs are load-use dependencies, EX-stage redirects (taken branch or jump) and instruction/data bus wait states. It also keeps a bus-stall watchdog and three stall/flush performance counters.

## Interface
- TIMEOUT, 1024: consecutive bus-stall cycles before `bus_timeout` sets (1..65535).
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- im_wait  in  1  instruction-memory wrapper not ready this cycle
- dm_wait  in  1  data-memory wrapper not ready this cycle
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  EX destination register
- id_rs1, id_rs2  in  5 each  ID source registers
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1/rs2
- ex_redirect  in  1  EX branch taken or jump (PC redirect)
- bus_stall  out  2  {dm_wait, im_wait}; nonzero freezes the whole pipeline
- instr_sel  out  2  IF/ID select: 00 pass, 01 replay held instr, 10 inject NOP
- load_use  out  1  load-use stall this cycle (IF/ID holds pc_ID)
- pc_en  out  1  PC register update enable
- id_ex_bubble  out  1  load NOP into ID/EX this cycle
- bus_timeout  out  1  sticky watchdog flag
- cnt_lu, cnt_flush, cnt_bus  out  32 each  performance counters

## Operation
- FSM states are RUN and REPLAY. The reset state is RUN.
- Hazard terms, all combinational:
  - bs = im_wait | dm_wait.
  - hz = ex_mem_read & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- Priority is bus stall > redirect > load-use.
- RUN:
  - bs: all outputs hold off. instr_sel = 00, load_use = 0, id_ex_bubble = 0, pc_en = 0. State stays RUN.
  - else ex_redirect: instr_sel = 10, id_ex_bubble = 1, pc_en = 1, load_use = 0. State stays RUN. IF/ID handles the second flush cycle itself.
  - else hz: load_use = 1, id_ex_bubble = 1, pc_en = 0, instr_sel = 00. Next state is REPLAY.
  - else: instr_sel = 00, pc_en = 1, others 0.
- REPLAY:
  - instr_sel = 01 and load_use = 0.
  - hz is ignored (no second stall for the same load).
  - bs: pc_en = 0, instr_sel stays 01, state stays REPLAY.
  - else ex_redirect: behaves as a RUN redirect (instr_sel = 10), next state RUN.
  - else: pc_en = 1, next state RUN.
- Watchdog:
  - stall_cnt (16 bit) increments each cycle bs = 1 and clears on any cycle with bs = 0.
  - When stall_cnt reaches TIMEOUT-1 with bs still high, bus_timeout sets on the next edge.
  - bus_timeout stays set until rst. The pipeline is not otherwise affected.
- Counters wrap modulo 2^32:
  - cnt_lu increments on each cycle with load_use = 1.
  - cnt_flush increments on each cycle with instr_sel = 10.
  - cnt_bus increments on each cycle with bs = 1.

## Timing
- All control outputs are combinational from the inputs and the registered state, valid in the same cycle. The only registered elements are the state, stall_cnt, bus_timeout and the counters.
- Load-use costs exactly one bubble: load_use in cycle N, instr_sel = 01 in the first non-bus-stalled cycle after N.
- Reset values: state RUN, stall_cnt 0, bus_timeout 0, counters 0. Outputs under reset are instr_sel 00, load_use 0, id_ex_bubble 0, pc_en = !(im_wait | dm_wait).
- rst mid-REPLAY returns the FSM to RUN immediately; no replay follows.
- Simultaneous hz and ex_redirect: redirect wins, no stall, no REPLAY, cnt_lu unchanged.
- hz with ex_rd = 0 never stalls.

## Test plan
- Load x5 then add x6,x5,x1, no waits:
  - cycle N: load_use = 1, pc_en = 0, id_ex_bubble = 1.
  - cycle N+1: instr_sel = 01, pc_en = 1.
  - cnt_lu = 1.
- Same as above with dm_wait = 1 for 3 cycles starting at N+1: instr_sel holds 01 and pc_en = 0 for 3 cycles, then one cycle of 01 with pc_en = 1, then 00; cnt_bus = 3.
- ex_redirect with hz both high: instr_sel = 10, load_use = 0, FSM stays RUN; cnt_flush = 1, cnt_lu = 0.
- im_wait and ex_redirect high together for 2 cycles, then im_wait low: the first two cycles give instr_sel 00 and pc_en 0; the third cycle gives instr_sel 10.
- TIMEOUT = 4, dm_wait high 4 cycles: bus_timeout rises after the 4th edge and stays 1 after dm_wait falls. With only 3 cycles high it stays 0.
- Assert rst while in REPLAY: all counters read 0, instr_sel = 00 on the next cycle, no replay cycle.
